// File: rtl/tick_mon_pkg.sv
// -----------------------------------------------------------------------------
// tick_mon_pkg
// Shared types and constants for the tick_monitor block.
//   state_e   : measurement FSM states (IDLE, RUN, LOST)
//   ERR_CNT_W : width of the saturating error counter
// -----------------------------------------------------------------------------
package tick_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOST = 2'd2
    } state_e;

    localparam int ERR_CNT_W = 8;

endpackage : tick_mon_pkg

// File: rtl/tick_mon_sat_counter.sv
// -----------------------------------------------------------------------------
// tick_mon_sat_counter
// Saturating incrementer with synchronous active-high reset.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset (clears count)
//   inc   : add one this cycle (ignored once the count is all-ones)
//   count : current count value
// -----------------------------------------------------------------------------
module tick_mon_sat_counter
    import tick_mon_pkg::*;
#(
    parameter int W = ERR_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : tick_mon_sat_counter

// File: rtl/tick_monitor.sv
// -----------------------------------------------------------------------------
// tick_monitor
// Receive-side checker for a single-cycle periodic tick strobe. Measures the
// number of clk cycles between successive ticks, reports each period, flags
// early and late (missing) ticks, tracks lock and keeps a saturating error
// count. All outputs are registered and appear one cycle after the event.
//
// Optional feature (macro TICK_MON_HIST_EN): adds hist_clr input and
// min_period / max_period outputs tracking the extremes of reported periods.
//
// Ports:
//   clk          : system clock
//   reset        : synchronous, active-high reset
//   tick         : strobe under test, every high cycle is one tick
//   period       : last measured interval in cycles
//   period_valid : one-cycle pulse when period updates
//   early_err    : one-cycle pulse, interval below EXPECTED_PERIOD-TOLERANCE
//   late_err     : one-cycle pulse, no tick by EXPECTED_PERIOD+TOLERANCE
//   locked       : last interval in tolerance and no timeout since
//   err_count    : saturating count of early/late events
//   hist_clr     : (hist only) restart min/max tracking
//   min_period   : (hist only) smallest period since reset/clear
//   max_period   : (hist only) largest period since reset/clear
// -----------------------------------------------------------------------------
module tick_monitor
    import tick_mon_pkg::*;
#(
    parameter int EXPECTED_PERIOD = 1_000_001,
    parameter int TOLERANCE       = 16,
    parameter int CNT_W           = $clog2(EXPECTED_PERIOD + TOLERANCE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
`ifdef TICK_MON_HIST_EN
    input  logic                 hist_clr,
    output logic [CNT_W-1:0]     min_period,
    output logic [CNT_W-1:0]     max_period,
`endif
    output logic [CNT_W-1:0]     period,
    output logic                 period_valid,
    output logic                 early_err,
    output logic                 late_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] LO_LIM = CNT_W'(EXPECTED_PERIOD - TOLERANCE);
    localparam logic [CNT_W-1:0] HI_LIM = CNT_W'(EXPECTED_PERIOD + TOLERANCE);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             early_q, early_d;
    logic             late_q, late_d;
    logic             locked_q, locked_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        early_d        = 1'b0;
        late_d         = 1'b0;
        locked_d       = locked_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    cnt_d   = CNT_W'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                // A tick arriving exactly at HI_LIM wins over the timeout.
                if (tick) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    cnt_d          = CNT_W'(1);
                    if (cnt_q < LO_LIM) begin
                        early_d  = 1'b1;
                        locked_d = 1'b0;
                    end else begin
                        locked_d = 1'b1;
                    end
                end else if (cnt_q == HI_LIM) begin
                    // cnt parks at HI_LIM so it can never wrap while lost.
                    late_d   = 1'b1;
                    locked_d = 1'b0;
                    state_d  = LOST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOST: begin
                // Interval is unknown after a timeout, so nothing is reported.
                if (tick) begin
                    cnt_d   = CNT_W'(1);
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            early_q        <= 1'b0;
            late_q         <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            early_q        <= early_d;
            late_q         <= late_d;
            locked_q       <= locked_d;
        end
    end

    // Counter sees the same next-state event as the pulse registers, so the
    // count changes in the cycle the error pulse is visible.
    tick_mon_sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (early_d | late_d),
        .count (err_count)
    );

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign early_err    = early_q;
    assign late_err     = late_q;
    assign locked       = locked_q;

`ifdef TICK_MON_HIST_EN
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             seen_q, seen_d;

    // Tracking follows the period register, so min/max are current in the
    // same cycle period_valid is seen. A clear in the update cycle still lets
    // that period seed both registers.
    always_comb begin
        min_d  = min_q;
        max_d  = max_q;
        seen_d = seen_q;
        if (hist_clr) begin
            min_d  = '1;
            max_d  = '0;
            seen_d = 1'b0;
        end
        if (period_valid_d) begin
            seen_d = 1'b1;
            if (!seen_q || hist_clr) begin
                min_d = period_d;
                max_d = period_d;
            end else begin
                if (period_d < min_q) min_d = period_d;
                if (period_d > max_q) max_d = period_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min_q  <= '1;
            max_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            min_q  <= min_d;
            max_q  <= max_d;
            seen_q <= seen_d;
        end
    end

    assign min_period = min_q;
    assign max_period = max_q;
`endif

endmodule : tick_monitor

// File: tb/tb_tick_monitor.sv
// -----------------------------------------------------------------------------
// tb_tick_monitor
// Scoreboard bench for tick_monitor with EXPECTED_PERIOD=10, TOLERANCE=2
// (in-tolerance window 8..12). The stimulus process drives tick intervals and
// pushes hand-computed expected responses; the monitor pops and compares
// whenever the DUT pulses period_valid, early_err or late_err. Static output
// snapshots (reset, after clear) go through a second queue to the monitor.
// Hist checks are active when TICK_MON_HIST_EN is defined.
// -----------------------------------------------------------------------------
module tb_tick_monitor;

    localparam int EP = 10;
    localparam int TOL = 2;
    localparam int CW = $clog2(EP + TOL + 1);

    typedef struct {
        logic [CW-1:0] period;
        logic          pv;
        logic          early;
        logic          late;
        logic          locked;
        logic [7:0]    errc;
        logic          chk_hist;
        logic [CW-1:0] mn;
        logic [CW-1:0] mx;
        string         name;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          hist_clr = 1'b0;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          early_err;
    logic          late_err;
    logic          locked;
    logic [7:0]    err_count;
    logic [CW-1:0] min_period;
    logic [CW-1:0] max_period;

    exp_t exp_q[$];
    exp_t snap_q[$];
    logic done = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tick_monitor #(
        .EXPECTED_PERIOD (EP),
        .TOLERANCE       (TOL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
`ifdef TICK_MON_HIST_EN
        .hist_clr     (hist_clr),
        .min_period   (min_period),
        .max_period   (max_period),
`endif
        .period       (period),
        .period_valid (period_valid),
        .early_err    (early_err),
        .late_err     (late_err),
        .locked       (locked),
        .err_count    (err_count)
    );

`ifndef TICK_MON_HIST_EN
    assign min_period = '1;
    assign max_period = '0;
`endif

    function automatic exp_t mk(string name, int p, bit pv, bit e, bit l, bit lk,
                                int ec, bit ch, int mn, int mx);
        exp_t x;
        x.name = name;
        x.period = CW'(p);
        x.pv = pv;
        x.early = e;
        x.late = l;
        x.locked = lk;
        x.errc = 8'(ec);
        x.chk_hist = ch;
        x.mn = CW'(mn);
        x.mx = CW'(mx);
        return x;
    endfunction

    // One interval of `gap` cycles: gap-1 low cycles then one high cycle.
    task automatic send(input int gap);
        for (int i = 0; i < gap - 1; i++) begin
            tick = 1'b0;
            @(posedge clk); #1;
        end
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    // Monitor / scoreboard: the only process that compares and counts.
    always @(negedge clk) begin
        exp_t x;
        bit ok;
        if (!reset && (period_valid || early_err || late_err)) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got period=%0d pv=%0b early=%0b late=%0b locked=%0b err=%0d, required no event",
                         period, period_valid, early_err, late_err, locked, err_count);
            end else begin
                x = exp_q.pop_front();
                ok = (period == x.period) && (period_valid == x.pv) && (early_err == x.early) &&
                     (late_err == x.late) && (locked == x.locked) && (err_count == x.errc);
`ifdef TICK_MON_HIST_EN
                if (x.chk_hist) ok = ok && (min_period == x.mn) && (max_period == x.mx);
`endif
                if (!ok) begin
                    fails++;
                    $display("FAIL %s: got p=%0d pv=%0b e=%0b l=%0b lk=%0b err=%0d min=%0d max=%0d, required p=%0d pv=%0b e=%0b l=%0b lk=%0b err=%0d min=%0d max=%0d",
                             x.name, period, period_valid, early_err, late_err, locked, err_count,
                             min_period, max_period, x.period, x.pv, x.early, x.late, x.locked,
                             x.errc, x.mn, x.mx);
                end else begin
                    $display("[TB] %s: p=%0d e=%0b l=%0b lk=%0b err=%0d ok", x.name, period,
                             early_err, late_err, locked, err_count);
                end
            end
        end
        if (snap_q.size() != 0) begin
            x = snap_q.pop_front();
            tests++;
            ok = (period == x.period) && (period_valid == x.pv) && (early_err == x.early) &&
                 (late_err == x.late) && (locked == x.locked) && (err_count == x.errc);
`ifdef TICK_MON_HIST_EN
            if (x.chk_hist) ok = ok && (min_period == x.mn) && (max_period == x.mx);
`endif
            if (!ok) begin
                fails++;
                $display("FAIL %s: got p=%0d pv=%0b e=%0b l=%0b lk=%0b err=%0d min=%0d max=%0d, required p=%0d pv=%0b e=%0b l=%0b lk=%0b err=%0d min=%0d max=%0d",
                         x.name, period, period_valid, early_err, late_err, locked, err_count,
                         min_period, max_period, x.period, x.pv, x.early, x.late, x.locked,
                         x.errc, x.mn, x.mx);
            end else begin
                $display("[TB] %s: snapshot ok", x.name);
            end
        end
        if (done) begin
            tests++;
            if (exp_q.size() != 0) begin
                fails++;
                $display("FAIL missing_events: got %0d expected events never seen, required 0",
                         exp_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    initial begin
        // Reset state.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        snap_q.push_back(mk("reset_state", 0, 0, 0, 0, 0, 0, 1, 15, 0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Lock acquisition: first tick reports nothing.
        send(5);
        send(10); exp_q.push_back(mk("lock_p10", 10, 1, 0, 0, 1, 0, 1, 10, 10));
        send(10); exp_q.push_back(mk("steady_p10", 10, 1, 0, 0, 1, 0, 1, 10, 10));

        // Early tick, then recovery.
        send(7);  exp_q.push_back(mk("early_p7", 7, 1, 1, 0, 0, 1, 1, 7, 10));
        send(10); exp_q.push_back(mk("relock_p10", 10, 1, 0, 0, 1, 1, 1, 7, 10));

        // Tolerance edges 12 and 8 are in tolerance.
        send(12); exp_q.push_back(mk("edge_hi_p12", 12, 1, 0, 0, 1, 1, 1, 7, 12));
        send(8);  exp_q.push_back(mk("edge_lo_p8", 8, 1, 0, 0, 1, 1, 1, 7, 12));

        // Missing tick: exactly one late pulse, period register holds 8.
        exp_q.push_back(mk("late_timeout", 8, 0, 0, 1, 0, 2, 1, 7, 12));
        tick = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        send(3);  // tick out of LOST: no report
        send(10); exp_q.push_back(mk("after_lost_p10", 10, 1, 0, 0, 1, 2, 1, 7, 12));

        // Tick held high 300 cycles: each high cycle is an early period of 1.
        tick = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            exp_q.push_back(mk("hold_high", 1, 1, 1, 0, 0, (2 + k > 255) ? 255 : 2 + k, 1, 1, 12));
        end
        tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-RUN clears everything; next tick acts as first.
        reset = 1'b1;
        @(posedge clk); #1;
        snap_q.push_back(mk("mid_run_reset", 0, 0, 0, 0, 0, 0, 1, 15, 0));
        @(posedge clk); #1;
        reset = 1'b0;
        send(4);
        send(10); exp_q.push_back(mk("post_reset_p10", 10, 1, 0, 0, 1, 0, 1, 10, 10));

        // History extremes over 9, 11, 10.
        send(9);  exp_q.push_back(mk("hist_p9", 9, 1, 0, 0, 1, 0, 1, 9, 10));
        send(11); exp_q.push_back(mk("hist_p11", 11, 1, 0, 0, 1, 0, 1, 9, 11));
        send(10); exp_q.push_back(mk("hist_p10", 10, 1, 0, 0, 1, 0, 1, 9, 11));

        // Clear history one cycle after the last tick; the next send(9)
        // completes an interval of 10 counting that cycle.
        hist_clr = 1'b1;
        @(posedge clk); #1;
        hist_clr = 1'b0;
        snap_q.push_back(mk("hist_cleared", 10, 0, 0, 0, 1, 0, 1, 15, 0));
        send(9);  exp_q.push_back(mk("hist_reload_p10", 10, 1, 0, 0, 1, 0, 1, 10, 10));

        repeat (4) @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule : tb_tick_monitor

// File: doc/tick_monitor.md
Name: tick_monitor

Overview:
- Receive-side checker for the single-cycle periodic `tick` strobe produced by the team's tick generators. Consumer blocks such as the upcounter and the SPI/I2C pacing logic use that strobe.
- Measures clk cycles between successive ticks and reports each measured period.
- Flags early or late (missing) ticks, keeps lock status and a saturating error count.
- Sits beside the tick consumer for in-system health monitoring and bench self-checking.

Parameters:
- EXPECTED_PERIOD, 1_000_001, nominal tick interval in clk cycles.
- TOLERANCE, 16, allowed deviation either side of EXPECTED_PERIOD in cycles; must be less than EXPECTED_PERIOD.
- CNT_W, $clog2(EXPECTED_PERIOD+TOLERANCE+1), width of the interval counter and of `period`.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tick  input  1  strobe under test; every high cycle is one tick
- period  output  CNT_W  last measured interval in cycles
- period_valid  output  1  one-cycle pulse when `period` updates
- early_err  output  1  one-cycle pulse: interval < EXPECTED_PERIOD-TOLERANCE
- late_err  output  1  one-cycle pulse: no tick by EXPECTED_PERIOD+TOLERANCE
- locked  output  1  level: last interval was in tolerance and no timeout since
- err_count  output  8  saturating count of early_err plus late_err events

Behaviour:
- Reset is synchronous and active-high; clk is the only clock.
- On reset, all outputs are 0, state is IDLE and cnt is 0. Reset asserted mid-measurement discards that measurement; the next tick after reset is treated as the first.
- The interval counter `cnt` equals 1 in the cycle after a tick and increments by 1 each cycle while in RUN.
- All outputs are registered; each output reflects the event 1 cycle after the tick or timeout cycle.
- FSM IDLE: on tick, set cnt<=1 and go to RUN. No period is reported.
- FSM RUN, tick seen:
  - period<=cnt, period_valid pulses, cnt<=1, state stays RUN.
  - If cnt < EXPECTED_PERIOD-TOLERANCE: early_err pulses and locked<=0.
  - Otherwise: locked<=1.
- FSM RUN, no tick and cnt==EXPECTED_PERIOD+TOLERANCE:
  - late_err pulses, locked<=0, go to LOST. cnt holds, so there is no wrap.
- FSM LOST: cnt holds. On tick, cnt<=1 and go to RUN; no period_valid, because the interval is unknown.
- Boundary: a tick in the same cycle cnt reaches EXPECTED_PERIOD+TOLERANCE is in tolerance. The tick wins and no late_err is raised.
- Boundary: cnt==EXPECTED_PERIOD-TOLERANCE is in tolerance.
- Tick held high for N cycles counts as N ticks. Each high cycle after the first measures period 1, giving early_err.
- err_count increments by 1 per error event and saturates at 255. early_err and late_err can never pulse in the same cycle.

Optional Feature:
- Macro TICK_MON_HIST_EN.
- When defined, adds:
  - input hist_clr (1 bit)
  - outputs min_period and max_period (CNT_W each)
- min_period and max_period update on every period_valid. The first valid period after reset or hist_clr loads both.
- Before the first valid period, min_period resets to all-ones and max_period resets to 0.
- hist_clr is synchronous, and its effect is visible next cycle. If hist_clr coincides with period_valid, that period loads both registers.
- When undefined, none of these ports or registers exist, and behaviour is otherwise identical.

Decomposition:
- Package tick_mon_pkg:
  - state enum typedef {IDLE, RUN, LOST}
  - ERR_CNT_W = 8 constant
- One natural sub-module: tick_mon_sat_counter (8-bit saturating incrementer with synchronous reset), instantiated for err_count.
- The history logic stays inline under the macro.

Test Plan (EXPECTED_PERIOD=10, TOLERANCE=2):
- Reset, then ticks every 10 cycles -> first tick gives no period_valid; second tick gives period=10, period_valid=1 for 1 cycle and locked=1; err_count=0.
- After lock, next tick 7 cycles later -> period=7, early_err pulse, locked=0, err_count=1; a following 10-cycle interval gives locked=1.
- Ticks at intervals 12 then 8 -> both reported, no errors, locked stays 1.
- Tick stopped -> late_err pulses once when cnt=12, locked=0, no further pulses; next tick gives no period_valid; tick 10 cycles later gives period=10.
- Tick held high 300 cycles -> err_count saturates at 255; reset asserted mid-RUN zeroes all outputs and the next tick behaves as first.
- With TICK_MON_HIST_EN, intervals 9, 11, 10 -> min_period=9, max_period=11; hist_clr then an interval of 10 -> min_period=max_period=10.
